// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// Data requests win unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDRW        = 32,
  parameter int XLEN         = 32,
  parameter int MASKW        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             imem_valid_i,
  input  logic [ADDRW-1:0] imem_addr_i,
  output logic             imem_ready_o,
  output logic             imem_rvalid_o,
  output logic [XLEN-1:0]  imem_rdata_o,
  input  logic             dmem_valid_i,
  input  logic [ADDRW-1:0] dmem_addr_i,
  input  logic [MASKW-1:0] dmem_mask_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  input  logic             dmem_we_i,
  output logic             dmem_ready_o,
  output logic             dmem_rvalid_o,
  output logic [XLEN-1:0]  dmem_rdata_o,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic             mem_we_o,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i
);

  localparam int CNTW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  localparam logic OWNER_IMEM = 1'b0;
  localparam logic OWNER_DMEM = 1'b1;

  logic [1:0]       state;
  logic             owner;
  logic [ADDRW-1:0] addr;
  logic [MASKW-1:0] mask;
  logic [XLEN-1:0]  wdata;
  logic             we;
  logic [CNTW-1:0]  starve_cnt;

  logic idle;
  logic starved;
  logic grant_d;
  logic grant_i;
  logic rsp;

  // Everything is qualified by rst_i so all outputs read 0 during the reset cycle.
  always_comb begin
    idle    = rst_i && (state == IDLE);
    starved = imem_valid_i && (starve_cnt == CNTW'(STARVE_LIMIT));
    grant_d = idle && dmem_valid_i && !starved;
    grant_i = idle && imem_valid_i && !grant_d;
    rsp     = rst_i && (state == WAIT_RSP) && mem_rvalid_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      owner      <= OWNER_IMEM;
      addr       <= '0;
      mask       <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner <= OWNER_DMEM;
            addr  <= dmem_addr_i;
            mask  <= dmem_mask_i;
            wdata <= dmem_wdata_i;
            we    <= dmem_we_i;
            state <= ISSUE;
            if (!imem_valid_i) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNTW'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + CNTW'(1);
            end
          end else if (grant_i) begin
            owner      <= OWNER_IMEM;
            addr       <= imem_addr_i;
            mask       <= '1;
            wdata      <= '0;
            we         <= 1'b0;
            state      <= ISSUE;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (mem_ready_i) begin
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    imem_ready_o  = grant_i;
    dmem_ready_o  = grant_d;
    mem_valid_o   = rst_i && (state == ISSUE);
    mem_addr_o    = rst_i ? addr  : '0;
    mem_mask_o    = rst_i ? mask  : '0;
    mem_wdata_o   = rst_i ? wdata : '0;
    mem_we_o      = rst_i && we;
    imem_rvalid_o = rsp && (owner == OWNER_IMEM);
    dmem_rvalid_o = rsp && (owner == OWNER_DMEM);
    imem_rdata_o  = mem_rdata_i;
    dmem_rdata_o  = mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts grants, bus beats and routed responses; a negedge monitor checks them.
module tb_mem_port_arbiter;
  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = 4;
  localparam int LIMIT = 4;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_RSP  = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             imem_valid_i = 1'b0;
  logic [ADDRW-1:0] imem_addr_i = '0;
  logic             imem_ready_o, imem_rvalid_o;
  logic [XLEN-1:0]  imem_rdata_o;
  logic             dmem_valid_i = 1'b0;
  logic [ADDRW-1:0] dmem_addr_i = '0;
  logic [MASKW-1:0] dmem_mask_i = '0;
  logic [XLEN-1:0]  dmem_wdata_i = '0;
  logic             dmem_we_i = 1'b0;
  logic             dmem_ready_o, dmem_rvalid_o;
  logic [XLEN-1:0]  dmem_rdata_o;
  logic             mem_valid_o;
  logic             mem_ready_i = 1'b0;
  logic [ADDRW-1:0] mem_addr_o;
  logic [MASKW-1:0] mem_mask_o;
  logic [XLEN-1:0]  mem_wdata_o;
  logic             mem_we_o;
  logic             mem_rvalid_i = 1'b0;
  logic [XLEN-1:0]  mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .MASKW(MASKW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_valid_i(imem_valid_i), .imem_addr_i(imem_addr_i), .imem_ready_o(imem_ready_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i), .dmem_mask_i(dmem_mask_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_ready_o(dmem_ready_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_mask_o(mem_mask_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [MASKW-1:0] mask;
    logic [XLEN-1:0]  wdata;
    logic             we;
  } bus_t;

  typedef struct packed {
    logic            dmem;
    logic [XLEN-1:0] data;
  } rsp_t;

  bus_t exp_bus[$];
  logic exp_grant[$];
  rsp_t exp_rsp[$];

  int total = 0;
  int bad   = 0;

  // Presence expectations for the current cycle, set by the driver.
  logic want_grant = 1'b0;
  logic want_valid = 1'b0;
  logic want_rsp   = 1'b0;
  logic in_reset   = 1'b1;

  // Reference model state
  int               phase  = P_IDLE;
  int               streak = 0;
  logic             owner_d = 1'b0;
  logic             i_pend = 1'b0;
  logic             d_pend = 1'b0;
  logic [ADDRW-1:0] i_addr = '0;
  logic [ADDRW-1:0] d_addr = '0;
  logic [MASKW-1:0] d_mask = '0;
  logic [XLEN-1:0]  d_wdata = '0;
  logic             d_we = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    bus_t b;
    rsp_t r;
    logic g;
    if (in_reset) begin
      check("reset_outputs",
            {mem_valid_o, imem_ready_o, dmem_ready_o, imem_rvalid_o, dmem_rvalid_o,
             mem_addr_o, mem_mask_o, mem_wdata_o, mem_we_o}, '0);
    end else begin
      check("grant_present", {127'd0, imem_ready_o | dmem_ready_o}, {127'd0, want_grant});
      if ((imem_ready_o || dmem_ready_o) && exp_grant.size() > 0) begin
        g = exp_grant.pop_front();
        check("grant_owner", {imem_ready_o, dmem_ready_o}, g ? 2'b01 : 2'b10);
      end
      check("bus_valid", {127'd0, mem_valid_o}, {127'd0, want_valid});
      if (mem_valid_o && exp_bus.size() > 0) begin
        b = exp_bus[0];
        check("bus_addr", mem_addr_o, b.addr);
        check("bus_mask", mem_mask_o, b.mask);
        check("bus_wdata", mem_wdata_o, b.wdata);
        check("bus_we", mem_we_o, b.we);
        if (mem_ready_i) void'(exp_bus.pop_front());
      end
      check("rsp_present", {127'd0, imem_rvalid_o | dmem_rvalid_o}, {127'd0, want_rsp});
      if ((imem_rvalid_o || dmem_rvalid_o) && exp_rsp.size() > 0) begin
        r = exp_rsp.pop_front();
        check("rsp_owner", {imem_rvalid_o, dmem_rvalid_o}, r.dmem ? 2'b01 : 2'b10);
        check("rsp_data", r.dmem ? dmem_rdata_o : imem_rdata_o, r.data);
      end
    end
  end

  task automatic step(input int p_req, input int p_ready, input int p_rsp,
                      input bit noise, input bit force_rv);
    bus_t b;
    rsp_t r;
    @(posedge clk);
    #1;
    rst_i    = 1'b1;
    in_reset = 1'b0;
    if (!i_pend && $urandom_range(99) < p_req) begin
      i_pend = 1'b1;
      i_addr = $urandom() & ~32'h3;
    end
    if (!d_pend && $urandom_range(99) < p_req) begin
      d_pend  = 1'b1;
      d_addr  = $urandom() & ~32'h3;
      d_mask  = 4'($urandom_range(1, 15));
      d_wdata = $urandom();
      d_we    = 1'($urandom_range(1));
    end
    imem_valid_i = i_pend;
    imem_addr_i  = i_addr;
    dmem_valid_i = d_pend;
    dmem_addr_i  = d_addr;
    dmem_mask_i  = d_mask;
    dmem_wdata_i = d_wdata;
    dmem_we_i    = d_we;
    mem_rdata_i  = $urandom();
    want_grant = 1'b0;
    want_valid = 1'b0;
    want_rsp   = 1'b0;
    mem_ready_i  = noise && ($urandom_range(1) == 1);
    mem_rvalid_i = force_rv || (noise && ($urandom_range(1) == 1));
    case (phase)
      P_IDLE: begin
        if (d_pend && !(i_pend && streak == LIMIT)) begin
          b = '{addr: d_addr, mask: d_mask, wdata: d_wdata, we: d_we};
          streak  = i_pend ? streak + 1 : 0;
          owner_d = 1'b1;
          d_pend  = 1'b0;
        end else if (i_pend) begin
          b = '{addr: i_addr, mask: '1, wdata: '0, we: 1'b0};
          streak  = 0;
          owner_d = 1'b0;
          i_pend  = 1'b0;
        end
        if (imem_valid_i || dmem_valid_i) begin
          exp_grant.push_back(owner_d);
          exp_bus.push_back(b);
          want_grant = 1'b1;
          phase = P_REQ;
        end
      end
      P_REQ: begin
        want_valid  = 1'b1;
        mem_ready_i = ($urandom_range(99) < p_ready);
        if (mem_ready_i) phase = P_RSP;
      end
      default: begin
        mem_rvalid_i = ($urandom_range(99) < p_rsp);
        if (mem_rvalid_i) begin
          r = '{dmem: owner_d, data: mem_rdata_i};
          exp_rsp.push_back(r);
          want_rsp = 1'b1;
          phase = P_IDLE;
        end
      end
    endcase
  endtask

  // Held requests survive reset; the abandoned transaction's expectations do not.
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      rst_i        = 1'b0;
      in_reset     = 1'b1;
      want_grant   = 1'b0;
      want_valid   = 1'b0;
      want_rsp     = 1'b0;
      mem_ready_i  = 1'($urandom_range(1));
      mem_rvalid_i = 1'($urandom_range(1));
      mem_rdata_i  = $urandom();
    end
    phase  = P_IDLE;
    streak = 0;
    exp_bus.delete();
    exp_grant.delete();
    exp_rsp.delete();
  endtask

  initial begin
    do_reset(2);
    for (int i = 0; i < 300; i++) step(30, 60, 60, 1'b1, 1'b0);
    // Both requesters always pending on a zero-wait bus: D,D,D,D,I pattern.
    for (int i = 0; i < 200; i++) step(100, 100, 100, 1'b0, 1'b0);
    // Long bus stalls.
    for (int i = 0; i < 200; i++) step(50, 15, 40, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10 + k * 7; i++) step(100, 100, 100, 1'b0, 1'b0);
      for (int i = 0; i < 10 && phase != P_RSP; i++) step(100, 100, 0, 1'b0, 1'b0);
      do_reset(1);
      step(100, 100, 100, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) step(60, 70, 70, 1'b1, 1'b0);
    end
    for (int i = 0; i < 40; i++) step(0, 100, 100, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("drain_bus", exp_bus.size(), 0);
    check("drain_grant", exp_grant.size(), 0);
    check("drain_rsp", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
